// File: rtl/cbus_arbiter_rr.sv
// CBus request/response types and an N-channel CBus arbiter with fixed-priority or
// round-robin policy; a grant is held until the downstream returns the last beat.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_arbiter_rr
  import cbus_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned POLICY = 0,
  parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  cbus_req_t  [NUM_CH-1:0] ireqs,
  output cbus_resp_t [NUM_CH-1:0] iresps,
  output cbus_req_t               oreq,
  input  cbus_resp_t              oresp,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_idx
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] winner;
  logic             any_valid;
  logic             done;
  int unsigned      scan;

  // Scan from rr_ptr (round-robin) or from 0 (fixed), wrapping explicitly at NUM_CH.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    scan      = 0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      scan = (POLICY == 1) ? 32'(rr_ptr_q) + off : off;
      if (scan >= NUM_CH) begin
        scan = scan - NUM_CH;
      end
      if (!any_valid && ireqs[IDX_W'(scan)].valid) begin
        any_valid = 1'b1;
        winner    = IDX_W'(scan);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_ptr_d  = rr_ptr_q;
    oreq      = '0;
    iresps    = '0;
    busy      = 1'b0;
    grant_idx = '0;
    done      = oresp.ready && oresp.last;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          sel_d   = winner;
          state_d = StBusy;
        end
      end
      StBusy: begin
        oreq          = ireqs[sel_q];
        iresps[sel_q] = oresp;
        busy          = 1'b1;
        grant_idx     = sel_q;
        // No arbitration in the completion cycle: one idle bubble always follows.
        if (done) begin
          state_d = StIdle;
          if (POLICY == 1) begin
            rr_ptr_d = (sel_q == IDX_W'(NUM_CH - 1)) ? '0 : sel_q + IDX_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
